// File: rtl/wb_block_master_pkg.sv
// Purpose : shared constants for the Wishbone block master (cycle-type tags, FSM states).
// Latency : n/a (package only).
// Backpr. : n/a.
package wb_block_master_pkg;

    // Wishbone cycle-type identifiers driven on m_tag_o
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Tag for the beat about to be presented: classic cycles never carry a
    // burst tag; in burst mode the final beat announces end-of-burst.
    function automatic logic [2:0] cti_for(input logic burst, input logic last);
        if (!burst)
            return CTI_CLASSIC;
        return last ? CTI_END : CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_block_master.sv
// Purpose : Wishbone initiator moving a block of consecutive words between a
//           local cmd/stream port and a Wishbone responder (burst or classic).
// Latency : cmd -> first stb 1 cycle; read data 1 (classic) / 2 (burst) cycles after ack.
// Backpr. : write stream stalls stb while wr_valid=0; read stream has no backpressure.
//
// Ports: clk/reset (async active-low); cmd_* block request (we, first addr, len);
//        wr_dat/wr_valid/wr_ready write stream; rd_dat/rd_valid read stream;
//        done/err end-of-block pulse; m_* Wishbone master port (m_rty_i unused).
module wb_block_master
    import wb_block_master_pkg::*;
#(
    parameter int Dw       = 32,
    parameter int Aw       = 10,
    parameter int TAGw     = 3,
    parameter int SELw     = 4,
    parameter int LENw     = 8,
    parameter int BURST_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [Aw-1:0]   cmd_addr,
    input  logic [LENw-1:0] cmd_len,
    input  logic [Dw-1:0]   wr_dat,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic [Dw-1:0]   rd_dat,
    output logic            rd_valid,
    output logic            done,
    output logic            err,
    output logic [Dw-1:0]   m_dat_o,
    output logic [Aw-1:0]   m_addr_o,
    output logic [SELw-1:0] m_sel_o,
    output logic [TAGw-1:0] m_tag_o,
    output logic            m_stb_o,
    output logic            m_cyc_o,
    output logic            m_we_o,
    input  logic [Dw-1:0]   m_dat_i,
    input  logic            m_ack_i,
    input  logic            m_err_i,
    input  logic            m_rty_i
);

    localparam logic BURST = (BURST_EN != 0);

    state_t          state_q,    state_d;
    logic            we_q,       we_d;
    logic [Aw-1:0]   addr_q,     addr_d;
    logic [LENw-1:0] rem_q,      rem_d;
    logic [TAGw-1:0] tag_q,      tag_d;
    logic            cyc_q,      cyc_d;
    logic            stb_q,      stb_d;
    logic            ack_d_q,    ack_d_d;     // burst read beat acked last cycle
    logic [Dw-1:0]   rd_dat_q,   rd_dat_d;
    logic            rd_valid_q, rd_valid_d;
    logic            done_q,     done_d;
    logic            err_q,      err_d;

    logic beat_ack;
    logic beat_err;
    logic unused_rty;

    assign unused_rty = m_rty_i;

    // Write beats are only offered while the stream has a word; the registered
    // strobe is gated so a stall costs exactly the cycles wr_valid is low.
    assign m_stb_o  = stb_q & (~we_q | wr_valid);
    assign m_cyc_o  = cyc_q;
    assign m_we_o   = cyc_q & we_q;
    assign m_addr_o = addr_q;
    assign m_tag_o  = tag_q;
    assign m_sel_o  = '1;
    assign m_dat_o  = (cyc_q & we_q) ? wr_dat : '0;

    assign beat_ack = m_stb_o & m_ack_i;
    assign beat_err = m_stb_o & m_err_i;
    assign wr_ready = beat_ack & we_q;

    assign cmd_ready = (state_q == ST_IDLE);
    assign rd_dat    = rd_dat_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        tag_d      = tag_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        ack_d_d    = 1'b0;
        rd_dat_d   = rd_dat_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        // Burst responder returns read data the cycle after its ack; capture it
        // regardless of state so DRAIN and error aborts still deliver it.
        if (ack_d_q) begin
            rd_valid_d = 1'b1;
            rd_dat_d   = m_dat_i;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d   = cmd_we;
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_XFER;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        tag_d   = TAGw'(cti_for(BURST, cmd_len == LENw'(1)));
                    end
                end
            end
            ST_XFER: begin
                if (beat_err) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    tag_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (beat_ack) begin
                    addr_d = addr_q + Aw'(1);
                    rem_d  = rem_q - LENw'(1);
                    tag_d  = TAGw'(cti_for(BURST, rem_q == LENw'(2)));
                    if (!we_q) begin
                        if (BURST) begin
                            ack_d_d = 1'b1;
                        end else begin
                            rd_valid_d = 1'b1;
                            rd_dat_d   = m_dat_i;
                        end
                    end
                    if (rem_q == LENw'(1)) begin
                        cyc_d = 1'b0;
                        stb_d = 1'b0;
                        tag_d = '0;
                        // A burst read still owes one word from the responder.
                        if (we_q || !BURST) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            tag_q      <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            ack_d_q    <= 1'b0;
            rd_dat_q   <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            tag_q      <= tag_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            ack_d_q    <= ack_d_d;
            rd_dat_q   <= rd_dat_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_block_master.sv
// Purpose : directed bench for wb_block_master, burst and classic instances
//           sharing one RAM-style Wishbone responder model.
// Latency/Backpr. : responder acks combinationally for burst tags, one cycle
//           late for classic; write stream stalled once by the bench.
module tb_wb_block_master;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        cmd_we;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_dat;
    logic        wr_valid;
    logic        b_cmd_valid, c_cmd_valid;

    logic        b_cmd_ready, b_wr_ready, b_rd_valid, b_done, b_err;
    logic [31:0] b_rd_dat, b_m_dat_o;
    logic [9:0]  b_m_addr_o;
    logic [3:0]  b_m_sel_o;
    logic [2:0]  b_m_tag_o;
    logic        b_m_stb_o, b_m_cyc_o, b_m_we_o;

    logic        c_cmd_ready, c_wr_ready, c_rd_valid, c_done, c_err;
    logic [31:0] c_rd_dat, c_m_dat_o;
    logic [9:0]  c_m_addr_o;
    logic [3:0]  c_m_sel_o;
    logic [2:0]  c_m_tag_o;
    logic        c_m_stb_o, c_m_cyc_o, c_m_we_o;

    // responder model
    logic        sel_c;
    logic        err_en;
    logic [9:0]  err_addr;
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_dat;
    logic [31:0] mem [0:1023];
    logic [31:0] rdat_q;
    logic        ack_q;
    logic        bus_cyc, bus_stb, bus_we, bus_burst, ack_comb, err_comb;
    logic [9:0]  bus_addr;
    logic [31:0] bus_dat;
    logic        b_ack, c_ack, b_err_i, c_err_i;

    assign bus_cyc   = sel_c ? c_m_cyc_o  : b_m_cyc_o;
    assign bus_stb   = sel_c ? c_m_stb_o  : b_m_stb_o;
    assign bus_we    = sel_c ? c_m_we_o   : b_m_we_o;
    assign bus_addr  = sel_c ? c_m_addr_o : b_m_addr_o;
    assign bus_dat   = sel_c ? c_m_dat_o  : b_m_dat_o;
    assign bus_burst = (sel_c ? c_m_tag_o : b_m_tag_o) != 3'b000;
    assign err_comb  = err_en & bus_cyc & bus_stb & (bus_addr == err_addr);
    assign ack_comb  = ~err_comb & (bus_burst ? (bus_cyc & bus_stb) : ack_q);
    assign b_ack     = ack_comb & ~sel_c;
    assign c_ack     = ack_comb & sel_c;
    assign b_err_i   = err_comb & ~sel_c;
    assign c_err_i   = err_comb & sel_c;

    always @(posedge clk or negedge reset) begin
        if (!reset) ack_q <= 1'b0;
        else        ack_q <= bus_cyc & bus_stb & ~ack_q & ~bus_burst;
    end

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_dat;
        else if (bus_cyc && bus_stb && bus_we && ack_comb)
            mem[bus_addr] <= bus_dat;
        rdat_q <= mem[bus_addr];
    end

    wb_block_master #(.BURST_EN(1)) u_burst (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_dat(wr_dat), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
        .rd_dat(b_rd_dat), .rd_valid(b_rd_valid), .done(b_done), .err(b_err),
        .m_dat_o(b_m_dat_o), .m_addr_o(b_m_addr_o), .m_sel_o(b_m_sel_o),
        .m_tag_o(b_m_tag_o), .m_stb_o(b_m_stb_o), .m_cyc_o(b_m_cyc_o), .m_we_o(b_m_we_o),
        .m_dat_i(rdat_q), .m_ack_i(b_ack), .m_err_i(b_err_i), .m_rty_i(1'b0)
    );

    wb_block_master #(.BURST_EN(0)) u_classic (
        .clk(clk), .reset(reset),
        .cmd_valid(c_cmd_valid), .cmd_ready(c_cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_dat(wr_dat), .wr_valid(wr_valid), .wr_ready(c_wr_ready),
        .rd_dat(c_rd_dat), .rd_valid(c_rd_valid), .done(c_done), .err(c_err),
        .m_dat_o(c_m_dat_o), .m_addr_o(c_m_addr_o), .m_sel_o(c_m_sel_o),
        .m_tag_o(c_m_tag_o), .m_stb_o(c_m_stb_o), .m_cyc_o(c_m_cyc_o), .m_we_o(c_m_we_o),
        .m_dat_i(rdat_q), .m_ack_i(c_ack), .m_err_i(c_err_i), .m_rty_i(1'b0)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int idx;
    int rd_cnt;
    logic [31:0] wdata [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_dat  = d;
        adv();
        pl_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_dat = '0; wr_valid = 1'b0;
        b_cmd_valid = 1'b0; c_cmd_valid = 1'b0;
        sel_c = 1'b0; err_en = 1'b0; err_addr = '0;
        pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
        wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33;

        // reset state
        #2;
        check("rst cmd_ready", b_cmd_ready, 1);
        check("rst cyc", b_m_cyc_o, 0);
        check("rst done", b_done, 0);
        check("rst rd_valid", b_rd_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 4; i++) preload(10'h010 + 10'(i), 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) preload(10'h020 + 10'(i), 32'hB0 + 32'(i));
        preload(10'h3FF, 32'hC1);
        preload(10'h000, 32'hC0);

        // burst read, 4 words from 0x10
        adv();
        cmd_we = 1'b0; cmd_addr = 10'h010; cmd_len = 8'd4; b_cmd_valid = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            adv(); b_cmd_valid = 1'b0; smp();
            if (c <= 4) begin
                check($sformatf("brd c%0d ack", c), b_ack, 1);
                check($sformatf("brd c%0d addr", c), b_m_addr_o, 32'h10 + 32'(c - 1));
                check($sformatf("brd c%0d tag", c), b_m_tag_o, (c == 4) ? 7 : 2);
            end
            check($sformatf("brd c%0d rd_valid", c), b_rd_valid, (c >= 3 && c <= 6) ? 1 : 0);
            if (c >= 3 && c <= 6)
                check($sformatf("brd c%0d rd_dat", c), b_rd_dat, 32'hA0 + 32'(c - 3));
            check($sformatf("brd c%0d done", c), b_done, (c == 6) ? 1 : 0);
        end

        // classic read, 2 words wrapping 0x3FF -> 0x000
        adv();
        sel_c = 1'b1;
        cmd_we = 1'b0; cmd_addr = 10'h3FF; cmd_len = 8'd2; c_cmd_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            adv(); c_cmd_valid = 1'b0; smp();
            check($sformatf("cls c%0d cyc", c), c_m_cyc_o, (c <= 4) ? 1 : 0);
            if (c <= 4) check($sformatf("cls c%0d ack", c), c_ack, (c == 2 || c == 4) ? 1 : 0);
            if (c == 1) check("cls c1 addr", c_m_addr_o, 32'h3FF);
            if (c == 1) check("cls c1 tag", c_m_tag_o, 0);
            if (c == 3) check("cls c3 addr", c_m_addr_o, 32'h000);
            check($sformatf("cls c%0d rd_valid", c), c_rd_valid, (c == 3 || c == 5) ? 1 : 0);
            if (c == 3) check("cls c3 rd_dat", c_rd_dat, 32'hC1);
            if (c == 5) check("cls c5 rd_dat", c_rd_dat, 32'hC0);
            check($sformatf("cls c%0d done", c), c_done, (c == 5) ? 1 : 0);
        end

        // burst write of 3 words with one stream stall in cycle 2
        adv();
        sel_c = 1'b0;
        cmd_we = 1'b1; cmd_addr = 10'h040; cmd_len = 8'd3; b_cmd_valid = 1'b1;
        idx = 0; wr_valid = 1'b1; wr_dat = wdata[0];
        for (int c = 1; c <= 6; c++) begin
            adv();
            b_cmd_valid = 1'b0;
            wr_valid = (c != 2) && (idx < 3);
            wr_dat   = (idx < 3) ? wdata[idx] : 32'h0;
            smp();
            check($sformatf("bwr c%0d stb", c), b_m_stb_o, (c == 1 || c == 3 || c == 4) ? 1 : 0);
            check($sformatf("bwr c%0d wr_ready", c), b_wr_ready, (c == 1 || c == 3 || c == 4) ? 1 : 0);
            if (c == 3) check("bwr c3 tag", b_m_tag_o, 2);
            if (c == 4) check("bwr c4 tag", b_m_tag_o, 7);
            check($sformatf("bwr c%0d done", c), b_done, (c == 5) ? 1 : 0);
            if (c == 5) check("bwr c5 err", b_err, 0);
            if (c == 5) check("bwr c5 cmd_ready", b_cmd_ready, 1);
            if (b_wr_ready) idx++;
        end
        wr_valid = 1'b0;
        check("bwr words consumed", idx, 3);
        check("bwr mem 0x40", mem[10'h040], 32'h11);
        check("bwr mem 0x41", mem[10'h041], 32'h22);
        check("bwr mem 0x42", mem[10'h042], 32'h33);

        // zero-length command
        adv();
        cmd_we = 1'b0; cmd_addr = 10'h055; cmd_len = 8'd0; b_cmd_valid = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            adv(); b_cmd_valid = 1'b0; smp();
            check($sformatf("len0 c%0d done", c), b_done, (c == 1) ? 1 : 0);
            check($sformatf("len0 c%0d err", c), b_err, 0);
            check($sformatf("len0 c%0d cyc", c), b_m_cyc_o, 0);
        end

        // error on second beat of a 4-word burst read
        adv();
        err_en = 1'b1; err_addr = 10'h021;
        cmd_we = 1'b0; cmd_addr = 10'h020; cmd_len = 8'd4; b_cmd_valid = 1'b1;
        rd_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            adv(); b_cmd_valid = 1'b0; smp();
            if (b_rd_valid) rd_cnt++;
            if (c == 1) check("err c1 ack", b_ack, 1);
            if (c == 2) check("err c2 addr", b_m_addr_o, 32'h021);
            if (c == 3) begin
                check("err c3 cyc", b_m_cyc_o, 0);
                check("err c3 stb", b_m_stb_o, 0);
                check("err c3 rd_dat", b_rd_dat, 32'hB0);
            end
            check($sformatf("err c%0d done", c), b_done, (c == 3) ? 1 : 0);
            check($sformatf("err c%0d err", c), b_err, (c == 3) ? 1 : 0);
        end
        check("err words delivered", rd_cnt, 1);
        err_en = 1'b0;

        // reset mid-burst, then a fresh command
        adv();
        cmd_we = 1'b0; cmd_addr = 10'h010; cmd_len = 8'd4; b_cmd_valid = 1'b1;
        adv(); b_cmd_valid = 1'b0;
        adv(); reset = 1'b0; smp();
        check("rstm cyc", b_m_cyc_o, 0);
        check("rstm stb", b_m_stb_o, 0);
        check("rstm tag", b_m_tag_o, 0);
        check("rstm addr", b_m_addr_o, 0);
        check("rstm rd_valid", b_rd_valid, 0);
        check("rstm done", b_done, 0);
        check("rstm err", b_err, 0);
        for (int c = 3; c <= 4; c++) begin
            adv(); smp();
            check($sformatf("rstm hold c%0d rd_valid", c), b_rd_valid, 0);
            check($sformatf("rstm hold c%0d done", c), b_done, 0);
        end
        adv(); reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            smp();
            check($sformatf("rstm post%0d done", c), b_done, 0);
            check($sformatf("rstm post%0d cmd_ready", c), b_cmd_ready, 1);
            adv();
        end
        cmd_we = 1'b0; cmd_addr = 10'h012; cmd_len = 8'd2; b_cmd_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            adv(); b_cmd_valid = 1'b0; smp();
            if (c == 1) check("rst2 c1 tag", b_m_tag_o, 2);
            if (c == 2) check("rst2 c2 tag", b_m_tag_o, 7);
            check($sformatf("rst2 c%0d rd_valid", c), b_rd_valid, (c == 3 || c == 4) ? 1 : 0);
            if (c == 3) check("rst2 c3 rd_dat", b_rd_dat, 32'hA2);
            if (c == 4) check("rst2 c4 rd_dat", b_rd_dat, 32'hA3);
            check($sformatf("rst2 c%0d done", c), b_done, (c == 4) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
